// File: rtl/guard_recovery_ctrl_if.sv
// Bundle between the recovery sequencer, the AXI read/write guards, the reset
// unit and the register file. The sequencer connects through the slave
// modport. The master modport is the view of whatever drives the guard events
// and consumes the recovery status.
interface guard_recovery_ctrl_if #(
    parameter int IdWidth     = 4,
    parameter int AddrWidth   = 32,
    parameter int OutstWidth  = 4,
    parameter int BudgetWidth = 10,
    parameter int ErrCntWidth = 8
);
    // configuration from the register file
    logic                   cfg_enable_i;
    logic [BudgetWidth-1:0] drain_budget_i;

    // timeout events and in-flight counts from the guards
    logic                   rd_timeout_i;
    logic [IdWidth-1:0]     rd_id_i;
    logic [AddrWidth-1:0]   rd_addr_i;
    logic                   wr_timeout_i;
    logic [IdWidth-1:0]     wr_id_i;
    logic [AddrWidth-1:0]   wr_addr_i;
    logic [OutstWidth-1:0]  rd_outstanding_i;
    logic [OutstWidth-1:0]  wr_outstanding_i;

    // traffic gate and reset-unit handshake
    logic                   block_o;
    logic                   reset_req_o;
    logic                   reset_ack_i;

    // interrupt and error record
    logic                   irq_o;
    logic                   irq_clr_i;
    logic                   err_is_write_o;
    logic [IdWidth-1:0]     err_id_o;
    logic [AddrWidth-1:0]   err_addr_o;
    logic                   err_forced_o;
    logic                   err_multi_o;
    logic [ErrCntWidth-1:0] err_cnt_o;
    logic                   busy_o;

    modport slave (
        input  cfg_enable_i, drain_budget_i,
        input  rd_timeout_i, rd_id_i, rd_addr_i,
        input  wr_timeout_i, wr_id_i, wr_addr_i,
        input  rd_outstanding_i, wr_outstanding_i,
        input  reset_ack_i, irq_clr_i,
        output block_o, reset_req_o, irq_o,
        output err_is_write_o, err_id_o, err_addr_o,
        output err_forced_o, err_multi_o, err_cnt_o, busy_o
    );

    modport master (
        output cfg_enable_i, drain_budget_i,
        output rd_timeout_i, rd_id_i, rd_addr_i,
        output wr_timeout_i, wr_id_i, wr_addr_i,
        output rd_outstanding_i, wr_outstanding_i,
        output reset_ack_i, irq_clr_i,
        input  block_o, reset_req_o, irq_o,
        input  err_is_write_o, err_id_o, err_addr_o,
        input  err_forced_o, err_multi_o, err_cnt_o, busy_o
    );
endinterface

// File: rtl/guard_recovery_ctrl.sv
// Recovery sequencer for the AXI read/write guards.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | traffic open, waiting for a guard timeout
//   ST_DRAIN | AR/AW blocked, waiting for in-flight transactions or budget
//   ST_RESET | reset_req_o held high until the reset unit acknowledges
//   ST_HOLD  | settle for HoldCycles with traffic still blocked
//
// A timeout in IDLE is captured only while enabled. A timeout seen while busy
// is counted but never captured, and it never restarts the sequence. Once
// started, the sequence always runs to completion, even if the enable drops.
module guard_recovery_ctrl #(
    parameter int IdWidth     = 4,
    parameter int AddrWidth   = 32,
    parameter int OutstWidth  = 4,
    parameter int BudgetWidth = 10,
    parameter int HoldCycles  = 4,
    parameter int ErrCntWidth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    guard_recovery_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_RESET = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam int HoldW = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldCycles - 1);

    logic [1:0]             state_q, state_d;
    logic                   rr_q, rr_d;          // 0: read wins the next tie
    logic [BudgetWidth-1:0] timer_q, timer_d;
    logic [HoldW-1:0]       hold_q, hold_d;
    logic                   block_q, block_d;
    logic                   req_q, req_d;
    logic                   irq_q, irq_d;
    logic                   is_wr_q, is_wr_d;
    logic [IdWidth-1:0]     id_q, id_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic                   forced_q, forced_d;
    logic                   multi_q, multi_d;
    logic [ErrCntWidth-1:0] cnt_q, cnt_d;

    logic                   busy;
    logic                   any_to;
    logic                   both_to;
    logic                   count_ev;
    logic                   capture;
    logic                   win_wr;
    logic                   empty;
    logic [1:0]             n_ev;
    logic [ErrCntWidth-1:0] cnt_base;
    logic [ErrCntWidth:0]   cnt_sum;

    assign busy     = (state_q != ST_IDLE);
    assign any_to   = bus.rd_timeout_i | bus.wr_timeout_i;
    assign both_to  = bus.rd_timeout_i & bus.wr_timeout_i;
    // While busy, events are counted even with recovery disabled.
    assign count_ev = any_to & (busy | bus.cfg_enable_i);
    assign capture  = ~busy & bus.cfg_enable_i & any_to;
    assign win_wr   = both_to ? rr_q : bus.wr_timeout_i;
    assign empty    = (bus.rd_outstanding_i == '0) && (bus.wr_outstanding_i == '0);
    assign n_ev     = {1'b0, bus.rd_timeout_i} + {1'b0, bus.wr_timeout_i};

    // A clear in the same cycle as a new event restarts the count from zero.
    assign cnt_base = bus.irq_clr_i ? '0 : cnt_q;
    assign cnt_sum  = {1'b0, cnt_base} + {{(ErrCntWidth-1){1'b0}}, n_ev};

    // Next-state logic: sequencing, capture, arbitration, and error bookkeeping.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        timer_d  = timer_q;
        hold_d   = hold_q;
        block_d  = block_q;
        req_d    = req_q;
        irq_d    = irq_q;
        is_wr_d  = is_wr_q;
        id_d     = id_q;
        addr_d   = addr_q;
        forced_d = forced_q;
        multi_d  = multi_q;
        cnt_d    = cnt_q;

        if (bus.irq_clr_i) begin
            irq_d   = 1'b0;
            multi_d = 1'b0;
            cnt_d   = '0;
        end

        if (count_ev) begin
            irq_d = 1'b1;
            cnt_d = cnt_sum[ErrCntWidth] ? '1 : cnt_sum[ErrCntWidth-1:0];
            if (busy) begin
                multi_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d  = ST_DRAIN;
                    block_d  = 1'b1;
                    forced_d = 1'b0;
                    timer_d  = '0;
                    is_wr_d  = win_wr;
                    id_d     = win_wr ? bus.wr_id_i : bus.rd_id_i;
                    addr_d   = win_wr ? bus.wr_addr_i : bus.rd_addr_i;
                    // The pointer moves only when both guards fire together.
                    if (both_to) begin
                        rr_d    = ~rr_q;
                        multi_d = 1'b1;
                    end
                end
            end

            ST_DRAIN: begin
                // When both conditions hold, an empty pipe ends the drain
                // cleanly, so err_forced_o stays low.
                if (empty) begin
                    state_d = ST_RESET;
                    req_d   = 1'b1;
                    timer_d = '0;
                end else if (timer_q == bus.drain_budget_i) begin
                    state_d  = ST_RESET;
                    req_d    = 1'b1;
                    forced_d = 1'b1;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q + BudgetWidth'(1);
                end
            end

            ST_RESET: begin
                if (bus.reset_ack_i) begin
                    state_d = ST_HOLD;
                    req_d   = 1'b0;
                    hold_d  = '0;
                end
            end

            ST_HOLD: begin
                if (hold_q == HoldLast) begin
                    state_d = ST_IDLE;
                    block_d = 1'b0;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            rr_q     <= 1'b0;
            timer_q  <= '0;
            hold_q   <= '0;
            block_q  <= 1'b0;
            req_q    <= 1'b0;
            irq_q    <= 1'b0;
            is_wr_q  <= 1'b0;
            id_q     <= '0;
            addr_q   <= '0;
            forced_q <= 1'b0;
            multi_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            timer_q  <= timer_d;
            hold_q   <= hold_d;
            block_q  <= block_d;
            req_q    <= req_d;
            irq_q    <= irq_d;
            is_wr_q  <= is_wr_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            forced_q <= forced_d;
            multi_q  <= multi_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.block_o        = block_q;
    assign bus.reset_req_o    = req_q;
    assign bus.irq_o          = irq_q;
    assign bus.err_is_write_o = is_wr_q;
    assign bus.err_id_o       = id_q;
    assign bus.err_addr_o     = addr_q;
    assign bus.err_forced_o   = forced_q;
    assign bus.err_multi_o    = multi_q;
    assign bus.err_cnt_o      = cnt_q;
    assign bus.busy_o         = busy;

endmodule

// File: tb/tb_guard_recovery_ctrl.sv
// Bench for guard_recovery_ctrl. Each recovery episode is described by its
// stimulus parameters. The expected outcome is worked out arithmetically:
// drain length, forced flag, request length, hold length, the winner, and the
// counters. That outcome is queued when the timeout is issued. A monitor
// measures each block_o window and checks it against the queue.
module tb_guard_recovery_ctrl;
    localparam int IdW = 4, AW = 32, OW = 4, BW = 10, HC = 4, CW = 8;
    localparam int CntMax = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    guard_recovery_ctrl_if #(.IdWidth(IdW), .AddrWidth(AW), .OutstWidth(OW),
                             .BudgetWidth(BW), .ErrCntWidth(CW)) bus ();

    guard_recovery_ctrl #(.IdWidth(IdW), .AddrWidth(AW), .OutstWidth(OW),
                          .BudgetWidth(BW), .HoldCycles(HC), .ErrCntWidth(CW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        bit     is_write;
        int     id;
        longint addr;
        bit     forced;
        int     dlen;
        int     rlen;
        int     hlen;
        int     cnt;
        bit     multi;
        int     issue_cyc;
    } rec_t;

    rec_t sb_q[$];
    int   ntests = 0;
    int   nfail  = 0;
    int   cyc    = 0;

    // reference state: tie pointer, event count, sticky flags
    bit m_rr    = 1'b0;
    int m_cnt   = 0;
    bit m_multi = 1'b0;
    bit m_irq   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sat(input int v);
        return (v > CntMax) ? CntMax : v;
    endfunction

    function automatic int pop2(input int k);
        return (k & 1) + ((k >> 1) & 1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: measure each block window and score it against the queue.
    rec_t mon_r;
    bit   in_ep = 1'b0, prev_blk = 1'b0, ph = 1'b0;
    int   dl, rl, hl, rise_cyc;
    always @(negedge clk) begin
        if (rst) begin
            in_ep    = 1'b0;
            prev_blk = 1'b0;
        end else begin
            chk("busy_eq_block", bus.busy_o, bus.block_o);
            if (bus.block_o && !prev_blk) begin
                in_ep = 1'b1; dl = 0; rl = 0; hl = 0; ph = 1'b0; rise_cyc = cyc;
                chk("irq_at_capture", bus.irq_o, 1);
            end
            if (in_ep && bus.block_o) begin
                if (bus.reset_req_o) begin rl++; ph = 1'b1; end
                else if (!ph) dl++;
                else hl++;
            end else if (in_ep && !bus.block_o) begin
                in_ep = 1'b0;
                chk("sb_entry_available", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    mon_r = sb_q.pop_front();
                    chk("capture_latency", rise_cyc - mon_r.issue_cyc, 1);
                    chk("err_is_write", bus.err_is_write_o, mon_r.is_write);
                    chk("err_id", bus.err_id_o, mon_r.id);
                    chk("err_addr", bus.err_addr_o, mon_r.addr);
                    chk("err_forced", bus.err_forced_o, mon_r.forced);
                    chk("drain_cycles", dl, mon_r.dlen);
                    chk("reset_req_cycles", rl, mon_r.rlen);
                    chk("hold_cycles", hl, mon_r.hlen);
                    chk("err_cnt", bus.err_cnt_o, mon_r.cnt);
                    chk("err_multi", bus.err_multi_o, mon_r.multi);
                    chk("irq_sticky", bus.irq_o, 1);
                end
            end
            prev_blk = bus.block_o;
        end
    end

    // One full recovery. kind: 1=read, 2=write, 3=both. The outstanding counts
    // reach zero at DRAIN cycle z. Extra events of type ex_kind hit DRAIN
    // cycles ex_start .. ex_start+ex_n-1.
    task automatic run_ep(input int kind, input logic [3:0] id_r, input logic [31:0] addr_r,
                          input int z, input int budget, input int d,
                          input int ex_start, input int ex_n, input int ex_kind,
                          input bit clr_cap, input bit en_off);
        rec_t r;
        bit tie, seen;
        logic [3:0]  id_w;
        logic [31:0] addr_w;
        int ro, wo;
        id_w   = id_r ^ 4'h5;
        addr_w = ~addr_r;
        tie    = (kind == 3);
        r.is_write = tie ? m_rr : (kind == 2);
        if (tie) m_rr = !m_rr;
        if (clr_cap) begin m_cnt = 0; m_multi = 1'b0; end
        m_cnt = sat(m_cnt + pop2(kind));
        if (tie) m_multi = 1'b1;
        if (ex_n > 0) begin
            m_cnt   = sat(m_cnt + ex_n * pop2(ex_kind));
            m_multi = 1'b1;
        end
        m_irq    = 1'b1;
        r.id     = r.is_write ? int'(id_w) : int'(id_r);
        r.addr   = r.is_write ? longint'(addr_w) : longint'(addr_r);
        r.forced = (z > budget);
        r.dlen   = ((z < budget) ? z : budget) + 1;
        r.rlen   = d + 1;
        r.hlen   = HC;
        r.cnt    = m_cnt;
        r.multi  = m_multi;
        ro = $urandom_range(1, 15);
        wo = $urandom_range(0, 15);

        @(posedge clk); #1;
        bus.drain_budget_i   = BW'(budget);
        bus.rd_id_i          = id_r;
        bus.rd_addr_i        = addr_r;
        bus.wr_id_i          = id_w;
        bus.wr_addr_i        = addr_w;
        bus.irq_clr_i        = clr_cap;
        bus.rd_timeout_i     = kind[0];
        bus.wr_timeout_i     = kind[1];
        bus.rd_outstanding_i = (z == 0) ? '0 : OW'(ro);
        bus.wr_outstanding_i = (z == 0) ? '0 : OW'(wo);
        r.issue_cyc = cyc;
        sb_q.push_back(r);
        @(posedge clk); #1;
        bus.irq_clr_i    = 1'b0;
        bus.rd_timeout_i = 1'b0;
        bus.wr_timeout_i = 1'b0;

        seen = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (bus.reset_req_o) begin seen = 1'b1; break; end
            if (i == 0 && en_off) bus.cfg_enable_i = 1'b0;
            bus.rd_outstanding_i = (i >= z) ? '0 : OW'(ro);
            bus.wr_outstanding_i = (i >= z) ? '0 : OW'(wo);
            bus.rd_timeout_i = (i >= ex_start && i < ex_start + ex_n) ? ex_kind[0] : 1'b0;
            bus.wr_timeout_i = (i >= ex_start && i < ex_start + ex_n) ? ex_kind[1] : 1'b0;
            @(posedge clk); #1;
        end
        bus.rd_timeout_i = 1'b0;
        bus.wr_timeout_i = 1'b0;
        chk("reset_req_seen", seen, 1);

        repeat (d) begin @(posedge clk); #1; end
        bus.reset_ack_i = 1'b1;
        @(posedge clk); #1;
        bus.reset_ack_i = 1'b0;

        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (!bus.block_o) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("block_release_seen", seen, 1);
        bus.cfg_enable_i = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        bus.irq_clr_i = 1'b1;
        @(posedge clk); #1;
        bus.irq_clr_i = 1'b0;
        m_irq = 1'b0; m_cnt = 0; m_multi = 1'b0;
        chk("clr_irq", bus.irq_o, m_irq);
        chk("clr_cnt", bus.err_cnt_o, m_cnt);
        chk("clr_multi", bus.err_multi_o, m_multi);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, z, budget, d, dlen, exn, exs, exk;
        bit seen;
        rst = 1'b1;
        bus.cfg_enable_i = 1'b1;   bus.drain_budget_i = '0;
        bus.rd_timeout_i = 1'b0;   bus.rd_id_i = '0; bus.rd_addr_i = '0;
        bus.wr_timeout_i = 1'b0;   bus.wr_id_i = '0; bus.wr_addr_i = '0;
        bus.rd_outstanding_i = '0; bus.wr_outstanding_i = '0;
        bus.reset_ack_i = 1'b0;    bus.irq_clr_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_block", bus.block_o, 0);
        chk("rst_req", bus.reset_req_o, 0);
        chk("rst_irq", bus.irq_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_cnt", bus.err_cnt_o, 0);
        chk("rst_multi", bus.err_multi_o, 0);
        chk("rst_id", bus.err_id_o, 0);
        chk("rst_addr", bus.err_addr_o, 0);
        chk("rst_forced", bus.err_forced_o, 0);
        chk("rst_is_write", bus.err_is_write_o, 0);

        // single read timeout, pipe already empty, ack two cycles after request
        run_ep(1, 4'd3, 32'h1000, 0, 8, 2, 0, 0, 0, 1'b0, 1'b0);
        // write timeout with a stuck write counter hits the budget of 5
        run_ep(2, 4'd9, 32'h2000_0040, 1000, 5, 1, 0, 0, 0, 1'b0, 1'b0);
        // a pipe that empties exactly at the budget is not forced
        run_ep(1, 4'd1, 32'h44, 3, 3, 0, 0, 0, 0, 1'b0, 1'b0);

        // disabled recovery ignores a timeout in IDLE
        bus.cfg_enable_i = 1'b0;
        bus.rd_timeout_i = 1'b1;
        @(posedge clk); #1;
        bus.rd_timeout_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("dis_busy", bus.busy_o, 0);
            chk("dis_cnt", bus.err_cnt_o, m_cnt);
            @(posedge clk); #1;
        end
        bus.cfg_enable_i = 1'b1;

        // reset asserted in the middle of the reset handshake
        bus.drain_budget_i = BW'(3);
        bus.rd_outstanding_i = '0; bus.wr_outstanding_i = '0;
        bus.rd_timeout_i = 1'b1; bus.rd_id_i = 4'd7;
        @(posedge clk); #1;
        bus.rd_timeout_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.reset_req_o) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("rstmid_req_seen", seen, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_req", bus.reset_req_o, 0);
        chk("rstmid_block", bus.block_o, 0);
        chk("rstmid_busy", bus.busy_o, 0);
        chk("rstmid_irq", bus.irq_o, 0);
        chk("rstmid_cnt", bus.err_cnt_o, 0);
        chk("rstmid_id", bus.err_id_o, 0);
        rst = 1'b0;
        m_rr = 1'b0; m_cnt = 0; m_multi = 1'b0; m_irq = 1'b0;
        bus.reset_ack_i = 1'b1;
        @(posedge clk); #1;
        bus.reset_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late_ack_busy", bus.busy_o, 0);
            chk("late_ack_req", bus.reset_req_o, 0);
            @(posedge clk); #1;
        end

        // two ties separated by a full recovery: read wins first, then write
        run_ep(3, 4'd2, 32'hA0, 0, 4, 1, 0, 0, 0, 1'b0, 1'b0);
        run_ep(3, 4'd6, 32'hB0, 2, 4, 0, 0, 0, 0, 1'b0, 1'b0);
        chk("tie_cnt_total", bus.err_cnt_o, 4);

        // busy-time events, with the enable dropped mid-sequence; count saturates
        run_ep(1, 4'd5, 32'hC0DE, 1000, 400, 1, 0, 303, 1, 1'b0, 1'b1);
        chk("sat_cnt", bus.err_cnt_o, CntMax);
        do_clear();

        // clear and capture in the same cycle: the new event wins
        run_ep(1, 4'd8, 32'h3000, 0, 2, 0, 0, 0, 0, 1'b1, 1'b0);

        for (int ep = 0; ep < 25; ep++) begin
            kind   = $urandom_range(1, 3);
            z      = $urandom_range(0, 12);
            budget = $urandom_range(0, 10);
            d      = $urandom_range(0, 5);
            dlen   = ((z < budget) ? z : budget) + 1;
            exn    = $urandom_range(0, 3);
            if (exn > dlen) exn = dlen;
            exs    = $urandom_range(0, dlen - exn);
            exk    = $urandom_range(1, 3);
            run_ep(kind, 4'($urandom_range(0, 15)), $urandom, z, budget, d,
                   exs, exn, exk, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) do_clear();
        end

        repeat (5) @(posedge clk);
        #1;
        chk("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/guard_recovery_ctrl.md
Name: guard_recovery_ctrl

Overview:
- Recovery sequencer for the AXI read and write guards.
- On a guard timeout it captures the offending transaction and blocks new AR/AW acceptance.
- It then drains outstanding transactions under a cycle budget, performs a reset request/acknowledge handshake with the reset unit, holds for a settle interval, and reopens traffic.
- Raises a sticky interrupt with error info for the register file.

Parameters:
- IdWidth, 4, AXI ID width of captured transaction.
- AddrWidth, 32, captured address width.
- OutstWidth, 4, width of outstanding-transaction counts from the guards.
- BudgetWidth, 10, width of drain budget and drain timer.
- HoldCycles, 4, post-reset settle cycles (>=1).
- ErrCntWidth, 8, width of saturating timeout-event counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cfg_enable_i  in  1  recovery enable; when 0, timeouts in IDLE are ignored
- drain_budget_i  in  BudgetWidth  max cycles spent in DRAIN
- rd_timeout_i  in  1  read guard timeout pulse
- rd_id_i  in  IdWidth  ID of timed-out read
- rd_addr_i  in  AddrWidth  address of timed-out read
- wr_timeout_i  in  1  write guard timeout pulse
- wr_id_i  in  IdWidth  ID of timed-out write
- wr_addr_i  in  AddrWidth  address of timed-out write
- rd_outstanding_i  in  OutstWidth  reads in flight
- wr_outstanding_i  in  OutstWidth  writes in flight
- block_o  out  1  gate new AR/AW at both guards
- reset_req_o  out  1  reset request to reset unit
- reset_ack_i  in  1  reset unit acknowledge
- irq_o  out  1  sticky interrupt
- irq_clr_i  in  1  clears irq_o, err_multi_o, err_cnt_o
- err_is_write_o  out  1  captured event came from the write guard
- err_id_o  out  IdWidth  captured ID
- err_addr_o  out  AddrWidth  captured address
- err_forced_o  out  1  drain ended by budget expiry, not by empty
- err_multi_o  out  1  additional timeout seen while busy or during tie
- err_cnt_o  out  ErrCntWidth  saturating count of timeout events
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; round-robin pointer = read; drain timer 0; hold counter 0.
- States: IDLE, DRAIN, RESET, HOLD.
- IDLE:
  - If cfg_enable_i and (rd_timeout_i or wr_timeout_i), move to DRAIN next cycle.
  - In that same next cycle: block_o=1, irq_o=1, err_* captured, err_forced_o cleared, err_cnt_o incremented by 1 per asserted timeout (saturating).
- Tie arbitration: if both timeouts are asserted, the round-robin pointer picks the winner (read first after reset), the pointer toggles, and err_multi_o is set. The pointer toggles only on ties.
- DRAIN:
  - Timer increments each cycle it is in DRAIN, starting at 0.
  - If rd_outstanding_i==0 and wr_outstanding_i==0, go to RESET.
  - Else if timer==drain_budget_i, go to RESET and set err_forced_o.
  - Empty has priority over budget.
  - With drain_budget_i==0: exactly one DRAIN cycle.
- RESET:
  - reset_req_o=1 throughout; it does not drop until reset_ack_i is sampled high.
  - On ack, go to HOLD next cycle with reset_req_o=0.
  - Ack outside RESET is ignored.
  - No timeout on the ack.
- HOLD:
  - Counts HoldCycles cycles with block_o=1, then goes to IDLE.
  - block_o=0 from the first IDLE cycle.
- Timeouts while busy_o=1:
  - Not captured; they do not restart the sequence.
  - err_cnt_o increments (saturating at all-ones); err_multi_o set.
  - Counted regardless of cfg_enable_i.
- cfg_enable_i=0 in IDLE: timeouts neither captured nor counted.
- Deassertion of cfg_enable_i mid-sequence does not abort; the sequence completes.
- irq_clr_i: clears irq_o, err_multi_o, err_cnt_o next cycle.
  - A same-cycle new capture or count wins: irq_o=1, err_cnt_o = number of new events.
  - err_id_o, err_addr_o, err_is_write_o, err_forced_o hold until the next capture.
- Capture latency: timeout pulse to block_o/irq_o is 1 cycle. Exit from HOLD to block_o low is 1 cycle.
- rst_i asserted in any state: next cycle IDLE with all outputs 0, including reset_req_o mid-handshake.

Test Plan:
- Single read timeout (id=3, addr=0x1000), outstanding already 0, ack 2 cycles after reset_req_o, HoldCycles=4 -> block_o/irq_o rise at t+1; DRAIN 1 cycle; reset_req_o high 3 cycles; block_o low 4 cycles after ack; err_id_o=3, err_addr_o=0x1000, err_forced_o=0.
- Write timeout with wr_outstanding_i stuck at 2, drain_budget_i=5 -> exactly 6 DRAIN cycles (timer 0..5); err_forced_o=1; err_is_write_o=1.
- Simultaneous rd/wr timeouts twice, separated by a full recovery -> first capture read, second capture write; err_multi_o=1; err_cnt_o=4 without clear.
- Three timeouts during DRAIN, plus 300 events with ErrCntWidth=8 -> no restart; err_cnt_o saturates at 255; irq_clr_i -> irq_o=0, err_cnt_o=0.
- cfg_enable_i=0 with rd_timeout_i pulse -> busy_o stays 0, err_cnt_o stays 0. Same-cycle irq_clr_i and timeout -> irq_o=1, err_cnt_o=1.
- rst_i asserted in RESET with reset_req_o=1 -> next cycle reset_req_o=0, block_o=0, busy_o=0; a later ack is ignored.
